// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack fetch from imem into an instruction register, valid/ready to decode (ILLEGAL_OP_CHECK_EN adds an opcode legality flag).
// Latency: instr_valid rises the cycle after imem_ack; at most one instruction per two cycles, no prefetch.
// Backpressure: instr/instr_pc held stable and no fetch issued until instr_ready or a branch redirect.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        instr_op,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DROP,
        S_VALID
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] seq_pc;

    assign tgt    = branch_target & ALIGN_MASK;
    assign seq_pc = ipc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            S_FETCH: begin
                if (imem_ack && branch_taken) begin
                    // Data for the old path is thrown away; new request goes out right away.
                    pc_d   = tgt;
                    addr_d = tgt;
                    req_d  = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = addr_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_VALID;
                end else if (branch_taken) begin
                    pc_d    = tgt;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (branch_taken) begin
                    pc_d = tgt;
                end
                if (imem_ack) begin
                    addr_d  = branch_taken ? tgt : pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = tgt;
                    addr_d  = tgt;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = seq_pc;
                    addr_d  = seq_pc;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

`ifdef ILLEGAL_OP_CHECK_EN
    function automatic logic op_illegal(input logic [5:0] op);
        return !((op == 6'b000000) || (op == 6'b100011) ||
                 (op == 6'b101011) || (op == 6'b000100));
    endfunction

    logic illegal_q, illegal_d;

    // Tracks the next instruction register contents, so it clears together with valid.
    always_comb begin
        illegal_d = valid_d && op_illegal(instr_d[31:26]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_op    = instr_q[31:26];
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps then random traffic against a transaction-level fetch model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef ILLEGAL_OP_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  instr_op;
    logic [31:0] instr_pc;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        illegal_op;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_op(instr_op), .instr_pc(instr_pc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: what should be requested, what is in flight, what is held for decode.
    bit          m_idle, m_inflight, m_killed, m_held;
    logic [31:0] m_next_pc, m_fl_addr, m_held_pc, m_held_dat;
    int          m_wait;
    int          lat_fixed;
    bit          ovr_vld;
    logic [31:0] ovr_dat;
    int          delivered;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit op_bad(input logic [5:0] op);
        return !(op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int next_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    task automatic model_init();
        m_idle = 1; m_inflight = 0; m_killed = 0; m_held = 0;
        m_next_pc = RESET_PC; m_fl_addr = '0; m_held_pc = '0; m_held_dat = '0; m_wait = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 0; imem_rdata = '0; branch_taken = 0; branch_target = '0; instr_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc", instr_pc, 0);
        chk("rst_ill", illegal_op, 0);
        model_init();
        rst_n = 1'b1;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy, input bit spur);
        bit          ack, real_ack, newreq;
        logic [31:0] rd;
        chk("req", imem_req, m_inflight);
        if (m_inflight) chk("addr", imem_addr, m_fl_addr);
        chk("valid", instr_valid, m_held);
        if (m_held) begin
            chk("instr", instr, m_held_dat);
            chk("instr_pc", instr_pc, m_held_pc);
            chk("instr_op", instr_op, m_held_dat[31:26]);
        end
        chk("illegal", illegal_op, ILL_EN && m_held && op_bad(m_held_dat[31:26]));
        ack = 0; rd = $urandom;
        if (m_inflight) begin
            if (m_wait == 0) begin
                ack = 1;
                rd = ovr_vld ? ovr_dat : memword(m_fl_addr);
            end else begin
                m_wait--;
            end
        end else begin
            ack = spur;
        end
        imem_ack = ack; imem_rdata = rd;
        branch_taken = br; branch_target = tgt; instr_ready = rdy;

        real_ack = ack && m_inflight;
        newreq = 0;
        if (m_idle) begin
            m_idle = 0;
            newreq = 1;
        end else begin
            if (br) begin
                m_next_pc = tgt & 32'hFFFF_FFFC;
                if (m_held) begin m_held = 0; newreq = 1; end
                if (m_inflight) m_killed = 1;
            end else if (m_held && rdy) begin
                m_held = 0;
                m_next_pc = m_held_pc + 32'd4;
                delivered++;
                newreq = 1;
            end
            if (real_ack) begin
                m_inflight = 0;
                if (m_killed) begin
                    newreq = 1;
                end else begin
                    m_held = 1; m_held_pc = m_fl_addr; m_held_dat = rd;
                end
            end
        end
        if (newreq) begin
            m_inflight = 1; m_killed = 0; m_fl_addr = m_next_pc; m_wait = next_lat();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_held();
        for (int i = 0; i < 20 && !m_held; i++) step(0, '0, 0, 0);
    endtask

    initial begin
        delivered = 0; lat_fixed = 2; ovr_vld = 0; ovr_dat = '0;
        model_init();
        #1;
        do_reset();

        // First fetch: branch in idle ignored, two wait cycles, load word.
        ovr_vld = 1; ovr_dat = 32'h8C220004;
        step(1, 32'h80, 0, 0);
        chk("first_addr", imem_addr, 32'h0);
        repeat (3) step(0, '0, 0, 0);
        chk("first_valid", instr_valid, 1);
        chk("first_op", instr_op, 6'b100011);
        chk("first_pc", instr_pc, 32'h0);

        // Stalled decode, with a stray ack that must be ignored.
        step(0, '0, 0, 1);
        repeat (4) step(0, '0, 0, 0);
        chk("hold_req", imem_req, 0);

        // Sequential fetches with ready high.
        ovr_vld = 0; lat_fixed = 0;
        step(0, '0, 1, 0);
        chk("seq_addr4", imem_addr, 32'h4);
        repeat (3) step(0, '0, 1, 0);
        chk("seq_addr8", imem_addr, 32'h8);
        lat_fixed = 3;
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("seq_addrC", imem_addr, 32'hC);

        // Redirect while the fetch is outstanding; its data must be dropped.
        ovr_vld = 1; ovr_dat = 32'h0;
        step(1, 32'h43, 0, 0);
        repeat (4) step(0, '0, 0, 0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_novalid", instr_valid, 0);

        // Branch beats ready in the valid state.
        ovr_vld = 0; lat_fixed = 1;
        wait_held();
        step(1, 32'h100, 1, 0);
        chk("br_vs_ready", imem_addr, 32'h100);

        // Opcode legality flag.
        ovr_vld = 1; ovr_dat = 32'hFC000000;
        wait_held();
        chk("ill_set", illegal_op, ILL_EN);
        step(0, '0, 1, 0);
        ovr_dat = 32'h10000000;
        wait_held();
        chk("ill_beq", illegal_op, 0);
        step(0, '0, 1, 0);

        // PC wrap at the top of the address space.
        ovr_vld = 0;
        wait_held();
        step(1, 32'hFFFF_FFFF, 0, 0);
        chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        wait_held();
        step(0, '0, 1, 0);
        chk("wrap_zero", imem_addr, 32'h0);

        // Random traffic.
        lat_fixed = -1;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 7) == 0,
                 ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a fetch drops the request immediately.
        for (int i = 0; i < 20 && !m_inflight; i++) step(0, '0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_valid", instr_valid, 0);
        do_reset();
        for (int i = 0; i < 40; i++) step(0, '0, $urandom_range(0, 1) == 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
